state_mem: RTL and testbench

Memory-access stage of the multi-cycle RISC-V32 custom CPU, downstream of the execute stage and feeding register write-back. It accepts one completed EX result at a time, performs at most one load or store over the valid/ready data-memory channels, and aligns and extends load data. It produces the register-file write and `complete_this`. It drives `fb_mem`, which holds the fetch stage in its commit state while a memory access is outstanding.

---
 rtl/state_mem.sv | 167 ++++++++++++++++
 tb/tb_state_mem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/state_mem.sv
// Memory-access stage: issues at most one load/store per EX result over the
// valid/ready data-memory channels, aligns/extends loads and produces the RF write.
module state_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] ex_result,
  input  logic [4:0]  rd,
  input  logic        reg_wen,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic        RF_wen,
  output logic [4:0]  RF_waddr,
  output logic [31:0] RF_wdata,
  output logic        complete_this,
  output logic        fb_mem,
  output logic [31:0] cpu_perf_cnt_ld,
  output logic [31:0] cpu_perf_cnt_st
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    ST   = 5'b00010,
    LD   = 5'b00100,
    RDW  = 5'b01000,
    WB   = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, sdata_q, exres_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] cnt_ld_q, cnt_st_q;
  logic [31:0] rsh_b, rsh_h, ld_ext;
  logic        take;

  assign take = (state_q == IDLE) && exe_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (exe_valid) state_d = is_store ? ST : (is_load ? LD : WB);
      ST:   if (Mem_Req_Ready) state_d = WB;
      LD:   if (Mem_Req_Ready) state_d = RDW;
      RDW:  if (Read_data_Valid) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load lane extraction from the latched byte address
  always_comb begin
    rsh_b = Read_data >> {addr_q[1:0], 3'b000};
    rsh_h = Read_data >> {addr_q[1], 4'b0000};
    unique case (op_q)
      3'b000:  ld_ext = {{24{rsh_b[7]}}, rsh_b[7:0]};
      3'b001:  ld_ext = {{16{rsh_h[15]}}, rsh_h[15:0]};
      3'b100:  ld_ext = {24'b0, rsh_b[7:0]};
      3'b101:  ld_ext = {16'b0, rsh_h[15:0]};
      default: ld_ext = Read_data;
    endcase
  end

  // RF write is staged so it is visible exactly in the WB cycle
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    unique case (state_q)
      IDLE: if (exe_valid && !is_store && !is_load) begin
        rf_wen_d   = reg_wen && (rd != 5'd0);
        rf_waddr_d = rd;
        rf_wdata_d = ex_result;
      end
      ST: if (Mem_Req_Ready) rf_waddr_d = rd_q;
      RDW: if (Read_data_Valid) begin
        rf_wen_d   = wen_q && (rd_q != 5'd0);
        rf_waddr_d = rd_q;
        rf_wdata_d = ld_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      exres_q    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_ld_q   <= '0;
      cnt_st_q   <= '0;
    end else begin
      state_q    <= state_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      if (take) begin
        addr_q  <= addr;
        sdata_q <= store_data;
        exres_q <= ex_result;
        op_q    <= mem_op;
        rd_q    <= rd;
        wen_q   <= reg_wen;
      end
      if (state_q == RDW && Read_data_Valid) cnt_ld_q <= cnt_ld_q + 32'd1;
      if (state_q == ST && Mem_Req_Ready)    cnt_st_q <= cnt_st_q + 32'd1;
    end
  end

  always_comb begin
    Write_strb = 4'b0000;
    Write_data = 32'd0;
    if (state_q == ST) begin
      unique case (op_q[1:0])
        2'b00: begin
          Write_strb = 4'b0001 << addr_q[1:0];
          Write_data = sdata_q << {addr_q[1:0], 3'b000};
        end
        2'b01: begin
          Write_strb = 4'b0011 << {addr_q[1], 1'b0};
          Write_data = sdata_q << {addr_q[1], 4'b0000};
        end
        default: begin
          Write_strb = 4'b1111;
          Write_data = sdata_q;
        end
      endcase
    end
  end

  assign MemWrite        = (state_q == ST);
  assign MemRead         = (state_q == LD);
  assign Address         = (MemWrite || MemRead) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign Read_data_Ready = (state_q == RDW);
  assign complete_this   = (state_q == WB);
  assign fb_mem          = (state_q == ST) || (state_q == LD) || (state_q == RDW) ||
                           (take && (is_load || is_store));
  assign RF_wen          = rf_wen_q;
  assign RF_waddr        = rf_waddr_q;
  assign RF_wdata        = rf_wdata_q;
  assign cpu_perf_cnt_ld = cnt_ld_q;
  assign cpu_perf_cnt_st = cnt_st_q;

endmodule

// File: tb/tb_state_mem.sv
// Scoreboard bench for state_mem: expected RF writes queued at issue, popped on complete_this.
module tb_state_mem;
  logic        clk = 0, rst = 1;
  logic        exe_valid = 0, is_load = 0, is_store = 0, reg_wen = 0;
  logic [2:0]  mem_op = 0;
  logic [31:0] addr = 0, store_data = 0, ex_result = 0, Read_data = 0;
  logic [4:0]  rd = 0;
  logic        Mem_Req_Ready = 0, Read_data_Valid = 0;
  logic [31:0] Address, Write_data, RF_wdata, cpu_perf_cnt_ld, cpu_perf_cnt_st;
  logic        MemWrite, MemRead, Read_data_Ready, RF_wen, complete_this, fb_mem;
  logic [3:0]  Write_strb;
  logic [4:0]  RF_waddr;

  typedef struct { bit wen; logic [4:0] waddr; logic [31:0] wdata; } exp_t;
  exp_t sbq[$];
  int nchk = 0, nerr = 0;
  logic [31:0] ldc = 0, stc = 0;

  always #5 clk = ~clk;

  state_mem dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .addr(addr), .store_data(store_data), .ex_result(ex_result), .rd(rd),
    .reg_wen(reg_wen), .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .RF_wen(RF_wen), .RF_waddr(RF_waddr), .RF_wdata(RF_wdata), .complete_this(complete_this),
    .fb_mem(fb_mem), .cpu_perf_cnt_ld(cpu_perf_cnt_ld), .cpu_perf_cnt_st(cpu_perf_cnt_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0] b; logic [15:0] h;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b100: return {24'h0, b};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Outcome monitor: RF_wen only ever in the completion cycle; completions pop the scoreboard
  always @(negedge clk) if (!rst) begin
    chk("rfwen_gate", {31'b0, RF_wen & ~complete_this}, 32'd0);
    if (complete_this) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rf_wen", {31'b0, RF_wen}, {31'b0, e.wen});
        if (e.wen) begin
          chk("rf_waddr", {27'b0, RF_waddr}, {27'b0, e.waddr});
          chk("rf_wdata", RF_wdata, e.wdata);
        end
      end
    end
  end

  task automatic run_op(input bit ld, input bit st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] exr, input logic [4:0] r,
                        input bit w, input int rstall, input int rwait, input logic [31:0] rdat,
                        input bit stray, input bit abort);
    bit lde;
    exp_t e;
    logic [3:0] xs; logic [31:0] xd;
    lde = ld & ~st;
    @(posedge clk); #1;
    exe_valid = 1; is_load = ld; is_store = st; mem_op = op; addr = a;
    store_data = sd; ex_result = exr; rd = r; reg_wen = w;
    if (!abort) begin
      e.wen = w && (r != 0) && !st;
      e.waddr = r;
      e.wdata = lde ? ld_model(op, a[1:0], rdat) : exr;
      sbq.push_back(e);
    end
    case (op[1:0])
      2'b00: begin xs = 4'b0001 << a[1:0]; xd = sd << (8 * a[1:0]); end
      2'b01: begin xs = a[1] ? 4'b1100 : 4'b0011; xd = a[1] ? {sd[15:0], 16'h0} : sd; end
      default: begin xs = 4'b1111; xd = sd; end
    endcase
    @(negedge clk);
    chk("fb_issue", {31'b0, fb_mem}, {31'b0, ld | st});
    @(posedge clk); #1;
    // inputs must be ignored once latched
    exe_valid = 0; is_load = $urandom; is_store = $urandom; addr = $urandom;
    store_data = $urandom; ex_result = $urandom; rd = $urandom; mem_op = $urandom;
    if (st || lde) begin
      for (int i = 0; i <= rstall; i++) begin
        Mem_Req_Ready = (i == rstall);
        Read_data_Valid = stray && lde && (i == 0);
        Read_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("req_valid", {30'b0, MemWrite, MemRead}, st ? 32'd2 : 32'd1);
        chk("req_addr", Address, {a[31:2], 2'b00});
        chk("rd_rdy_req", {31'b0, Read_data_Ready}, 32'd0);
        chk("fb_req", {31'b0, fb_mem}, 32'd1);
        if (st) begin
          chk("wstrb", {28'b0, Write_strb}, {28'b0, xs});
          chk("wdata", Write_data, xd);
        end
        @(posedge clk); #1;
      end
      Mem_Req_Ready = 0; Read_data_Valid = 0;
      if (st) stc++;
      if (lde) begin
        for (int i = 0; i <= rwait; i++) begin
          Read_data_Valid = (i == rwait) && !abort;
          Read_data = (i == rwait) ? rdat : $urandom;
          if (abort && i == rwait) rst = 1;
          @(negedge clk);
          chk("rd_rdy", {31'b0, Read_data_Ready}, 32'd1);
          chk("fb_rdw", {31'b0, fb_mem}, 32'd1);
          chk("rdw_noreq", {30'b0, MemWrite, MemRead}, 32'd0);
          @(posedge clk); #1;
        end
        Read_data_Valid = 0;
        if (abort) begin
          rst = 0;
          @(negedge clk);
          chk("abort_quiet", {27'b0, MemRead, MemWrite, Read_data_Ready, RF_wen, complete_this},
              32'd0);
          chk("abort_fb", {31'b0, fb_mem}, 32'd0);
          ldc = 0; stc = 0;
          chk("abort_cnt", cpu_perf_cnt_ld | cpu_perf_cnt_st, 32'd0);
          return;
        end
        ldc++;
      end
    end
    @(negedge clk);
    chk("complete", {31'b0, complete_this}, 32'd1);
    chk("fb_wb", {31'b0, fb_mem}, 32'd0);
    chk("cnt_ld", cpu_perf_cnt_ld, ldc);
    chk("cnt_st", cpu_perf_cnt_st, stc);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_pulse", {31'b0, complete_this}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ctl", {26'b0, MemWrite, MemRead, Read_data_Ready, RF_wen, complete_this, fb_mem},
          32'd0);
      chk("rst_data", Address | RF_wdata | {27'b0, RF_waddr} | {28'b0, Write_strb}, 32'd0);
      chk("rst_cnt", cpu_perf_cnt_ld | cpu_perf_cnt_st, 32'd0);
    end
    //     ld st op     addr          sdata         exres         rd  w  rs rw rdata         sy ab
    run_op(0, 0, 3'b000, 32'h0,        32'h0,        32'h1234,     5,  1, 0, 0, 32'h0,        0, 0);
    run_op(0, 1, 3'b000, 32'h1003,     32'hAB,       32'h0,        7,  0, 3, 0, 32'h0,        0, 0);
    run_op(1, 0, 3'b000, 32'h2001,     32'h0,        32'h0,        6,  1, 0, 0, 32'h00008000, 0, 0);
    run_op(1, 0, 3'b100, 32'h2001,     32'h0,        32'h0,        6,  1, 1, 1, 32'h00008000, 0, 0);
    run_op(1, 0, 3'b001, 32'h2002,     32'h0,        32'h0,        9,  1, 0, 2, 32'h80010000, 0, 0);
    run_op(1, 0, 3'b010, 32'h2004,     32'h0,        32'h0,        10, 1, 1, 5, 32'hCAFEF00D, 1, 0);
    run_op(1, 0, 3'b101, 32'h2006,     32'h0,        32'h0,        11, 1, 0, 0, 32'h9876ABCD, 1, 0);
    run_op(0, 1, 3'b001, 32'h4002,     32'h1234BEEF, 32'h0,        12, 1, 0, 0, 32'h0,        0, 0);
    run_op(1, 1, 3'b010, 32'h4005,     32'h55AA33CC, 32'h0,        13, 1, 2, 0, 32'h0,        0, 0);
    run_op(1, 0, 3'b000, 32'h4003,     32'h0,        32'h0,        0,  1, 0, 0, 32'h000000FF, 0, 0);
    run_op(0, 0, 3'b000, 32'h0,        32'h0,        32'hFFFF0001, 0,  1, 0, 0, 32'h0,        0, 0);
    run_op(1, 0, 3'b010, 32'h5000,     32'h0,        32'h0,        3,  1, 1, 2, 32'h11111111, 0, 1);
    run_op(0, 1, 3'b010, 32'h3000,     32'h89ABCDEF, 32'h0,        4,  0, 1, 0, 32'h0,        0, 0);
    for (int k = 0; k < 24; k++) begin
      int kind;
      logic [2:0] op;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: op = 3'b000; 1: op = 3'b001; 2: op = 3'b010; 3: op = 3'b100; default: op = 3'b101;
      endcase
      if (kind == 1) op = {1'b0, op[1:0]};
      run_op(kind == 2, kind == 1, op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom), 0);
    end
    repeat (2) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
